// File: rtl/sdram_pkg.sv
// Shared types and helpers for the SDRAM behavioural model.
//   sdram_cmd_e  : decoded command
//   decode_cmd   : {cs,ras,cas,we} -> command (strobes active-low)
//   bl_beats     : mode-register burst-length code -> beats (0 = unsupported code)
//   cl_cycles    : mode-register CAS-latency code -> cycles (0 = unsupported code)
//   wrap_col     : column of beat idx inside a BL-aligned wrap block
package sdram_pkg;

  typedef enum logic [2:0] {
    CmdNop,
    CmdAct,
    CmdRead,
    CmdWrite,
    CmdBst,
    CmdPre,
    CmdRef,
    CmdMrs
  } sdram_cmd_e;

  // Widest column address wrap_col handles; callers cast to their own width.
  localparam int unsigned ColMaxW = 16;

  function automatic sdram_cmd_e decode_cmd(input logic cs, input logic ras,
                                            input logic cas, input logic we);
    if (cs) return CmdNop;
    case ({ras, cas, we})
      3'b011:  return CmdAct;
      3'b101:  return CmdRead;
      3'b100:  return CmdWrite;
      3'b110:  return CmdBst;
      3'b010:  return CmdPre;
      3'b001:  return CmdRef;
      3'b000:  return CmdMrs;
      default: return CmdNop;
    endcase
  endfunction

  function automatic logic [3:0] bl_beats(input logic [2:0] code);
    case (code)
      3'b000:  return 4'd1;
      3'b001:  return 4'd2;
      3'b010:  return 4'd4;
      3'b011:  return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [1:0] cl_cycles(input logic [2:0] code);
    case (code)
      3'b010:  return 2'd2;
      3'b011:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Upper bits stay with the aligned block, low bits count modulo bl.
  function automatic logic [ColMaxW-1:0] wrap_col(input logic [ColMaxW-1:0] start,
                                                  input logic [3:0]         idx,
                                                  input logic [3:0]         bl);
    logic [ColMaxW-1:0] mask;
    mask = {{(ColMaxW - 4){1'b0}}, bl - 4'd1};
    return (start & ~mask) | ((start + {{(ColMaxW - 4){1'b0}}, idx}) & mask);
  endfunction

endpackage

// File: rtl/sdram_rd_pipe.sv
// CAS-latency read pipe: shift register of {valid, data}, stage 0 drives dq.
//   clk, rst_n  : clock, async active-low reset (empties the pipe)
//   en          : clock enable; when low the pipe holds
//   cl          : CAS latency in cycles (2 or 3)
//   push        : insert push_data so it reaches stage 0 cl-1 edges later
//   flush       : legal WRITE on the bus; drops pending beats and releases dq now
//   dq_out      : data of stage 0
//   dq_oe       : output enable for dq
module sdram_rd_pipe #(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [1:0]    cl,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          flush,
  output logic [DW-1:0] dq_out,
  output logic          dq_oe
);
  localparam int unsigned Depth = 3;

  logic [Depth-1:0] vld_q, vld_d;
  logic [DW-1:0]    dat_q [Depth];
  logic [DW-1:0]    dat_d [Depth];

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (en) begin
      if (flush) begin
        vld_d = '0;
      end else begin
        for (int i = 0; i < Depth - 1; i++) begin
          vld_d[i] = vld_q[i+1];
          dat_d[i] = dat_q[i+1];
        end
        vld_d[Depth-1] = 1'b0;
        // A newer command overwrites whatever would have shifted into its slot.
        if (push) begin
          vld_d[cl - 2'd1] = 1'b1;
          dat_d[cl - 2'd1] = push_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < Depth; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign dq_out = dat_q[0];
  // Release the bus combinationally so the controller's write data owns dq at the write edge.
  assign dq_oe  = vld_q[0] & ~flush;

endmodule

// File: rtl/sdram_model_mb.sv
// Cycle-accurate behavioural model of a single-data-rate SDRAM device.
//   clk, rst_n          : clock, async active-low reset
//   cke                 : clock enable; low ignores the command and freezes bursts
//   cs, ras, cas, we    : active-low command strobes
//   a                   : row / column address, MRS opcode, a[10] = precharge-all
//   ba                  : bank select
//   dqm                 : write byte mask (high = keep stored byte)
//   dq                  : bidirectional data bus, driven only for valid read beats
//   cmd_err             : one-cycle pulse after an illegal command
module sdram_model_mb
  import sdram_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned ROW_W = 13,
  parameter int unsigned COL_W = 9,
  parameter int unsigned BA_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cke,
  input  logic             cs,
  input  logic             ras,
  input  logic             cas,
  input  logic             we,
  input  logic [ROW_W-1:0] a,
  input  logic [BA_W-1:0]  ba,
  input  logic [DW/8-1:0]  dqm,
  inout  wire  [DW-1:0]    dq,
  output logic             cmd_err
);
  localparam int unsigned NB     = 2 ** BA_W;
  localparam int unsigned NBYTES = DW / 8;
  localparam int unsigned AW     = BA_W + ROW_W + COL_W;

  sdram_cmd_e cmd;
  logic       any_active, illegal, start, stop, wr_flush;
  logic [3:0] mrs_bl;
  logic [1:0] mrs_cl;

  logic [NB-1:0]    active_q, active_d;
  logic [ROW_W-1:0] open_row_q [NB];
  logic [ROW_W-1:0] open_row_d [NB];
  logic [3:0]       bl_q, bl_d;
  logic [1:0]       cl_q, cl_d;
  logic             err_q, err_d;

  // Burst in progress: beats still to go, next beat index, and its target.
  logic [3:0]       bur_left_q, bur_left_d;
  logic [3:0]       bur_idx_q, bur_idx_d;
  logic             bur_wr_q, bur_wr_d;
  logic [BA_W-1:0]  bur_bank_q, bur_bank_d;
  logic [ROW_W-1:0] bur_row_q, bur_row_d;
  logic [COL_W-1:0] bur_col_q, bur_col_d;

  logic             beat_v, beat_wr;
  logic [BA_W-1:0]  beat_bank;
  logic [ROW_W-1:0] beat_row;
  logic [COL_W-1:0] beat_col;
  logic [AW-1:0]    beat_addr;

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_data, pipe_data;
  logic          dq_oe;

  // Command decode and legality
  always_comb begin
    cmd        = cke ? decode_cmd(cs, ras, cas, we) : CmdNop;
    any_active = |active_q;
    mrs_bl     = bl_beats(a[2:0]);
    mrs_cl     = cl_cycles(a[6:4]);
    case (cmd)
      CmdAct:            illegal = active_q[ba];
      CmdRead, CmdWrite: illegal = ~active_q[ba];
      CmdRef:            illegal = any_active;
      CmdMrs:            illegal = any_active | (mrs_bl == 4'd0) | (mrs_cl == 2'd0);
      default:           illegal = 1'b0;
    endcase
    start    = ((cmd == CmdRead) || (cmd == CmdWrite)) && !illegal;
    stop     = (cmd == CmdBst) || ((cmd == CmdPre) && (a[10] || (ba == bur_bank_q)));
    wr_flush = start && (cmd == CmdWrite);
  end

  // Bank state and mode register
  always_comb begin
    active_d   = active_q;
    open_row_d = open_row_q;
    bl_d       = bl_q;
    cl_d       = cl_q;
    err_d      = illegal;
    case (cmd)
      CmdAct: begin
        if (!illegal) begin
          active_d[ba]   = 1'b1;
          open_row_d[ba] = a;
        end
      end
      CmdPre: begin
        if (a[10]) active_d = '0;
        else       active_d[ba] = 1'b0;
      end
      CmdMrs: begin
        // Each field updates only with a supported code.
        if (!any_active) begin
          if (mrs_bl != 4'd0) bl_d = mrs_bl;
          if (mrs_cl != 2'd0) cl_d = mrs_cl;
        end
      end
      default: ;
    endcase
  end

  // Burst engine: one beat per active edge, either from a new command or a running burst.
  always_comb begin
    bur_left_d = bur_left_q;
    bur_idx_d  = bur_idx_q;
    bur_wr_d   = bur_wr_q;
    bur_bank_d = bur_bank_q;
    bur_row_d  = bur_row_q;
    bur_col_d  = bur_col_q;
    beat_v     = 1'b0;
    beat_wr    = 1'b0;
    beat_bank  = bur_bank_q;
    beat_row   = bur_row_q;
    beat_col   = bur_col_q;
    if (start) begin
      beat_v     = 1'b1;
      beat_wr    = (cmd == CmdWrite);
      beat_bank  = ba;
      beat_row   = open_row_q[ba];
      beat_col   = a[COL_W-1:0];
      bur_left_d = bl_q - 4'd1;
      bur_idx_d  = 4'd1;
      bur_wr_d   = beat_wr;
      bur_bank_d = ba;
      bur_row_d  = open_row_q[ba];
      bur_col_d  = a[COL_W-1:0];
    end else if (stop) begin
      bur_left_d = 4'd0;
    end else if (cke && (bur_left_q != 4'd0)) begin
      beat_v     = 1'b1;
      beat_wr    = bur_wr_q;
      beat_col   = COL_W'(wrap_col(ColMaxW'(bur_col_q), bur_idx_q, bl_q));
      bur_left_d = bur_left_q - 4'd1;
      bur_idx_d  = bur_idx_q + 4'd1;
    end
  end

  assign beat_addr = {beat_bank, beat_row, beat_col};
  assign rd_data   = mem[beat_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= '0;
      for (int i = 0; i < NB; i++) open_row_q[i] <= '0;
      bl_q       <= 4'd1;
      cl_q       <= 2'd2;
      err_q      <= 1'b0;
      bur_left_q <= '0;
      bur_idx_q  <= '0;
      bur_wr_q   <= 1'b0;
      bur_bank_q <= '0;
      bur_row_q  <= '0;
      bur_col_q  <= '0;
    end else begin
      active_q   <= active_d;
      open_row_q <= open_row_d;
      bl_q       <= bl_d;
      cl_q       <= cl_d;
      err_q      <= err_d;
      bur_left_q <= bur_left_d;
      bur_idx_q  <= bur_idx_d;
      bur_wr_q   <= bur_wr_d;
      bur_bank_q <= bur_bank_d;
      bur_row_q  <= bur_row_d;
      bur_col_q  <= bur_col_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (beat_v && beat_wr) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (!dqm[i]) mem[beat_addr][8*i +: 8] <= dq[8*i +: 8];
      end
    end
  end

  sdram_rd_pipe #(
    .DW(DW)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (cke),
    .cl        (cl_q),
    .push      (beat_v & ~beat_wr),
    .push_data (rd_data),
    .flush     (wr_flush),
    .dq_out    (pipe_data),
    .dq_oe     (dq_oe)
  );

  assign dq      = dq_oe ? pipe_data : 'z;
  assign cmd_err = err_q;

endmodule

// File: doc/sdram_model_mb.md
# sdram_model_mb

Parametrised, cycle-accurate behavioural model of a single-data-rate SDRAM device for the SoC simulation environment. It sits on the memory side of the SDRAM controller, replacing the fixed 16-bit, 4-bank model. It generalises data width, bank count and geometry, and adds the following: per-bank open-row tracking, both CAS latencies, wrap-around bursts, burst terminate, precharge, refresh and a command-error flag.

## Interface
- `DW`, 16: data width; a multiple of 8.
- `ROW_W`, 13: row address bits. `a` width = `ROW_W`; `ROW_W` ≥ 11.
- `COL_W`, 9: column address bits; ≤ `ROW_W`-2.
- `BA_W`, 2: bank address bits; bank count = 2^`BA_W`.
- `clk` in 1: single clock; all commands are sampled on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `cke` in 1: clock enable. When low, the command is ignored and in-flight bursts freeze.
- `cs`, `ras`, `cas`, `we` in 1 each: command strobes, active-low.
- `a` in `ROW_W`: address/opcode.
- `ba` in `BA_W`: bank select.
- `dqm` in `DW/8`: byte mask. A bit high masks that byte on writes.
- `dq` inout `DW`: data bus.
- `cmd_err` out 1: one-cycle pulse on an illegal command.

## Operation
- **Command decode** from {cs,ras,cas,we} when `cke`=1:
  - 1xxx or 0111 → NOP
  - 0011 → ACT
  - 0101 → READ
  - 0100 → WRITE
  - 0110 → BST
  - 0010 → PRE (`a[10]`=1 means all banks)
  - 0001 → REF
  - 0000 → MRS
- **Per-bank state**: `active` bit plus `open_row` register.
  - ACT sets both for bank `ba`.
  - PRE clears `active` for `ba`, or for all banks when `a[10]`=1.
- **MRS** latches `a[2:0]` as burst length and `a[6:4]` as CAS latency.
  - Burst length: 000=1, 001=2, 010=4, 011=8.
  - CAS latency: 010=CL2, 011=CL3.
  - Other codes keep the previous value and pulse `cmd_err`.
- **Illegal commands pulse `cmd_err`, and the command is ignored**:
  - ACT to an active bank.
  - READ/WRITE to an idle bank.
  - REF or MRS while any bank is active.
- **READ** to bank b at column c:
  - Returns BL beats from `open_row[b]`.
  - Column sequence is sequential with wrap inside the BL-aligned block. Example: BL=4, c=6 gives 6,7,4,5.
  - `dqm` is ignored on reads.
- **WRITE**: the first beat is `dq` at the command edge; beats 2..BL follow on the next BL-1 active edges, using the same column wrap rule. Bytes with `dqm` high are left unchanged.
- **Burst termination**: a new READ or WRITE, BST or PRE to the bursting bank ends the current burst.
  - The new READ/WRITE starts at its own edge.
  - A write burst ends at once.
  - Read beats already issued (in the CL pipe) still appear on `dq`.
- **REF** has no effect on storage (the model does not decay).
- Storage is not reset. Unwritten locations read as X.

## Timing
- **Reset values**:
  - All banks idle; all `open_row` = 0.
  - Mode: BL=1, CL=2.
  - Burst counters 0; read pipe empty.
  - `dq` is high-Z; `cmd_err` = 0.
- Asserting `rst_n` mid-burst aborts the burst immediately: `dq` goes to Z in the same cycle.
- **Read latency**: a READ sampled at edge t drives beat k (k=0..BL-1) on `dq` from just after edge t+CL-1+k. Each beat is stable at edge t+CL+k.
- `dq` is driven only while a read beat is valid; otherwise it is Z.
- A WRITE issued at edge t+CL-1 while read data is still pending is legal. The pipe drops the pending beats, so `dq` is not driven at the write edge.
- **Back-to-back READs** on consecutive edges give gapless data; the newer command wins its own slots.
- **`cke`=0**: the burst counters, column counters and read pipe hold their value; `dq` keeps its current drive.
- `cmd_err` asserts for the cycle after the offending edge.

## Structure
- **`sdram_pkg`**:
  - Command enum.
  - Mode-register decode functions (BL code → beats, CL code → cycles).
  - The `wrap_col(start, idx, bl)` function.
- **Sub-module `sdram_rd_pipe`**: a CL-deep shift register of {valid, data}. It has a flush input for WRITE preemption and produces the `dq` output-enable.
- Top level holds:
  - Command decode.
  - Bank state array.
  - Burst counters.
  - Flat storage indexed as {bank, row, col}, with byte-masked writes.

## Test plan
- **Masked single write**: MRS BL=1 CL=2; ACT b1 r5; WRITE b1 c3 with `dq`=0xBEEF, `dqm`=01; then READ b1 c3. Required: `dq`=0xBE?? from the pre-existing data, with the low byte unchanged, valid 2 cycles after READ; `cmd_err` never pulses.
- **Wrap-around burst**: MRS BL=4 CL=3; WRITE c6 data 0x11,0x22,0x33,0x44 → READ c4 returns 0x33,0x44,0x11,0x22, with the first beat at edge t+3.
- **BST cuts a read**: BL=8 CL=2, READ at t, BST at t+2. Required: exactly 2 beats on `dq` (one more if the pipe holds one), then Z.
- **Illegal commands**:
  - READ to an idle bank → `cmd_err` pulse, `dq` stays Z.
  - ACT to an already-open bank → `cmd_err` pulse, `open_row` unchanged.
- **Reset mid-burst**: `rst_n` low during a BL=8 read. Required: `dq` is Z immediately; after release the mode reads back as BL=1/CL=2 and all banks are idle.
- **Parametrised config**: run with `DW`=32, `BA_W`=3. A write/read to bank 7 with mask 1010 preserves bytes 1 and 3.
